// File: rtl/parity_pipe_if.sv
// parity_pipe_if: in/out valid-ready streams of the parity pipe.
// slave = the pipe itself, master = the producer/consumer side.
`timescale 1ns/1ps
interface parity_pipe_if #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
);
    localparam int LANES = DATA_W / LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_check;
    logic [LANES-1:0]  in_par;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LANES-1:0]  out_par;
    logic              out_word_par;
    logic              out_err;

    modport slave (
        input  in_valid, in_data, in_check, in_par, out_ready,
        output in_ready, out_valid, out_data, out_par,
        output out_word_par, out_err
    );

    modport master (
        output in_valid, in_data, in_check, in_par, out_ready,
        input  in_ready, out_valid, out_data, out_par,
        input  out_word_par, out_err
    );
endinterface

// File: rtl/parity_pipe.sv
// parity_pipe: per-lane parity generate/check behind a 2-entry skid buffer.
// Define PARITY_ERR_CNT_EN to build the saturating error counter.
`timescale 1ns/1ps
module parity_pipe #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int ODD    = 0,
    localparam int LANES = DATA_W / LANE_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    parity_pipe_if.slave bus,
    output logic        err_sticky_o,
    output logic [15:0] err_count_o
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic ODD_B = (ODD != 0);

    state_t            state_q;
    logic              rdy_q;
    logic              vld_q;
    logic [DATA_W-1:0] hd_data_q, sk_data_q;
    logic [LANES-1:0]  hd_par_q, sk_par_q;
    logic              hd_wpar_q, sk_wpar_q;
    logic              hd_err_q, sk_err_q;
    logic              sticky_q, sticky_d;

    logic [LANES-1:0]  par_d;
    logic              wpar_d;
    logic              err_d;
    logic              acc;
    logic              dlv;

    // Reset forces both handshakes low while it is held.
    assign bus.in_ready     = rdy_q & ~rst_i;
    assign bus.out_valid    = vld_q & ~rst_i;
    assign bus.out_data     = hd_data_q;
    assign bus.out_par      = hd_par_q;
    assign bus.out_word_par = hd_wpar_q;
    assign bus.out_err      = hd_err_q;
    assign err_sticky_o     = sticky_q;

    assign acc = bus.in_valid & bus.in_ready;
    assign dlv = bus.out_valid & bus.out_ready;

    // Parity and error status of the word being offered.
    always_comb begin
        par_d = '0;
        for (int i = 0; i < LANES; i++) begin
            par_d[i] = (^bus.in_data[i*LANE_W +: LANE_W]) ^ ODD_B;
        end
        wpar_d = (^bus.in_data) ^ ODD_B;
        err_d  = bus.in_check & (par_d != bus.in_par);
    end

    // A delivery that carries an error wins over a same-cycle clear.
    always_comb begin
        sticky_d = clear_i ? 1'b0 : sticky_q;
        if (dlv && hd_err_q) sticky_d = 1'b1;
    end

    // Skid-buffer FSM; ready/valid are registered decodes of the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= EMPTY;
            rdy_q     <= 1'b1;
            vld_q     <= 1'b0;
            hd_data_q <= '0;
            hd_par_q  <= '0;
            hd_wpar_q <= 1'b0;
            hd_err_q  <= 1'b0;
            sk_data_q <= '0;
            sk_par_q  <= '0;
            sk_wpar_q <= 1'b0;
            sk_err_q  <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        hd_data_q <= bus.in_data;
                        hd_par_q  <= par_d;
                        hd_wpar_q <= wpar_d;
                        hd_err_q  <= err_d;
                        state_q   <= ONE;
                        vld_q     <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !dlv) begin
                        sk_data_q <= bus.in_data;
                        sk_par_q  <= par_d;
                        sk_wpar_q <= wpar_d;
                        sk_err_q  <= err_d;
                        state_q   <= TWO;
                        rdy_q     <= 1'b0;
                    end else if (acc && dlv) begin
                        hd_data_q <= bus.in_data;
                        hd_par_q  <= par_d;
                        hd_wpar_q <= wpar_d;
                        hd_err_q  <= err_d;
                    end else if (dlv) begin
                        state_q <= EMPTY;
                        vld_q   <= 1'b0;
                    end
                end
                TWO: begin
                    if (dlv) begin
                        hd_data_q <= sk_data_q;
                        hd_par_q  <= sk_par_q;
                        hd_wpar_q <= sk_wpar_q;
                        hd_err_q  <= sk_err_q;
                        state_q   <= ONE;
                        rdy_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b1;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count; an errored delivery during clear leaves it at 1.
    always_comb begin
        cnt_d = clear_i ? 16'd0 : cnt_q;
        if (dlv && hd_err_q) begin
            if (clear_i) begin
                cnt_d = 16'd1;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Error counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
    end

    assign err_count_o = cnt_q;
`else
    assign err_count_o = 16'h0000;
`endif
endmodule
